// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I funct3 codes,
// FSM state encoding and the latency counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a 32-bit memory word.
// Unrecognised funct3 values return the whole word (LW behaviour).
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  // Halfword lane uses addr[1] only; a set addr[0] is truncated here.
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: one request at a time, fixed LATENCY,
// one-cycle response. Define DMEM_MISALIGN_TRAP_EN to report misaligned/illegal accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;

  logic               r_we;
  logic [2:0]         r_funct3;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;

  logic [31:0]        r_mem [2**ADDR_W];

  logic               w_accept;
  logic               w_enter_resp;
  logic               w_we;
  logic [2:0]         w_funct3;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_err;
  logic [3:0]         w_be;
  logic [31:0]        w_wrep;
  logic               w_mem_we;
  logic [31:0]        w_load_data;
  logic               w_unused;

  assign w_accept = req_valid && r_req_ready;
  assign w_enter_resp = ((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                        ((r_state == WAIT) && (r_cnt == '0));

  // With LATENCY=1 the access happens on the accept edge, before the latch.
  assign w_we     = (r_state == IDLE) ? req_we     : r_we;
  assign w_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
  assign w_addr   = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_wdata  = (r_state == IDLE) ? req_wdata  : r_wdata;
  assign w_idx    = w_addr[ADDR_W+1:2];
  assign w_unused = ^w_addr[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    w_err = 1'b1;
    case (w_funct3)
      F3_B:    w_err = 1'b0;
      F3_H:    w_err = w_addr[0];
      F3_W:    w_err = |w_addr[1:0];
      F3_BU:   w_err = w_we;
      F3_HU:   w_err = w_we || w_addr[0];
      default: w_err = 1'b1;
    endcase
  end
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_be   = 4'b1111;
    w_wrep = w_wdata;
    case (w_funct3)
      F3_B: begin
        w_be   = 4'b0001 << w_addr[1:0];
        w_wrep = {4{w_wdata[7:0]}};
      end
      F3_H: begin
        w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wrep = w_wdata;
      end
    endcase
  end

  assign w_mem_we = rst && w_enter_resp && w_we && !w_err;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_mem_we && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
    end
  end

  load_align u_load_align (
    .i_word    (r_mem[w_idx]),
    .i_addr_lo (w_addr[1:0]),
    .i_funct3  (w_funct3),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= RESP;
          else r_cnt <= r_cnt - 1'b1;
        end
        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= (w_we || w_err) ? 32'd0 : w_load_data;
        r_rsp_err   <= w_err;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses from a
// byte-array reference model, monitor pops and compares on every rsp_valid.
module tb_dmem_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
  localparam int MEMB   = 4 * (1 << ADDR_W);

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mb [MEMB];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory, access size from funct3.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int          sz;
    int          base;
    bit          sgn;
    logic [31:0] v;
    case (f3)
      3'd0:    sz = 1;
      3'd1:    sz = 2;
      3'd4:    sz = we ? 4 : 1;
      3'd5:    sz = we ? 4 : 2;
      default: sz = 4;
    endcase
    sgn = (f3 == 3'd0) || (f3 == 3'd1);
    err = TRAP && ((f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) ||
                   (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
    rd = 32'd0;
    if (err) return;
    base = int'(a % MEMB) / sz * sz;
    if (we) begin
      for (int i = 0; i < sz; i++) mb[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[base + i];
      if (sz == 1)      rd = sgn ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
      else if (sz == 2) rd = sgn ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
      else              rd = v;
    end
  endfunction

  // Called at a negedge; returns at a negedge with req_ready high.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold,
                       input bit use_c, input logic [31:0] c_rd, input logic c_err);
    int          n;
    logic [31:0] mrd;
    logic        merr;
    exp_t        e;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: got req_ready=%b expected 1 within 50 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    model(we, f3, a, wd, mrd, merr);
    e.rd  = use_c ? c_rd : mrd;
    e.err = use_c ? c_err : merr;
    e.cyc = cyc + 1 + LAT;
    q.push_back(e);
    @(negedge clk);
    if (hold) begin
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("ready_low_cycles", n, LAT + 1);
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected no pending response (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rd);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] a;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) issue(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0, 1'b0, 32'd0, 1'b0);

    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'd0, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 3'd0, 32'h13, 32'd0, 1'b0, 1'b1, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 3'd4, 32'h13, 32'd0, 1'b0, 1'b1, 32'h000000DE, 1'b0);
    issue(1'b0, 3'd1, 32'h12, 32'd0, 1'b0, 1'b1, 32'hFFFFDEAD, 1'b0);
    issue(1'b1, 3'd0, 32'h11, 32'h55, 1'b0, 1'b1, 32'd0, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEAD55EF, 1'b0);
    if (TRAP) issue(1'b0, 3'd1, 32'h11, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1);
    else      issue(1'b0, 3'd1, 32'h11, 32'd0, 1'b0, 1'b1, 32'h000055EF, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 1'b1, 32'hDEAD55EF, 1'b0);

    // Back-to-back with req_valid held high and decoy requests during WAIT.
    issue(1'b1, 3'd2, 32'h20, 32'hA5A50F0F, 1'b1, 1'b1, 32'd0, 1'b0);
    issue(1'b0, 3'd2, 32'h20, 32'd0, 1'b1, 1'b1, 32'hA5A50F0F, 1'b0);
    issue(1'b0, 3'd5, 32'h22, 32'd0, 1'b1, 1'b1, 32'h0000A5A5, 1'b0);
    issue(1'b0, 3'd0, 32'h20, 32'd0, 1'b1, 1'b1, 32'h0000000F, 1'b0);
    req_valid = 1'b0;

    // Reset pulse while a store waits: no response, array unchanged.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_wait_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'd2, 32'h20, 32'd0, 1'b0, 1'b1, 32'hA5A50F0F, 1'b0);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0);
    end
    req_valid = 1'b0;

    repeat (10) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
